// File: rtl/act_mem_rotating_banks_pkg.sv
// act_mem_rotating_banks_pkg: shared sizes and word type for the rotating activation buffer
package act_mem_rotating_banks_pkg;
    localparam int N_DIM      = 16;
    localparam int DATA_W     = 8;
    localparam int N_BANKS    = 4;
    localparam int BANK_DEPTH = 256;
    localparam int N_DIM_LOG  = $clog2(N_DIM);
    localparam int DEPTH_LOG  = $clog2(BANK_DEPTH);
    localparam int BANK_LOG   = $clog2(N_BANKS);
    localparam int ADDR_W     = DEPTH_LOG + N_DIM_LOG;
    localparam int EXT_AW     = BANK_LOG + DEPTH_LOG;
    typedef logic [N_DIM*DATA_W-1:0] act_word_t;
endpackage

// File: rtl/act_mem_rotating_banks_if.sv
// act_mem_rotating_banks_if: compute, external and swap signals of the rotating activation buffer
interface act_mem_rotating_banks_if;
    import act_mem_rotating_banks_pkg::*;
    logic                rd_en, rd_parallel, rd_ready, rd_valid;
    logic [ADDR_W-1:0]   rd_addr;
    act_word_t           rd_data;
    logic                wr_en;
    logic [DEPTH_LOG-1:0] wr_addr;
    act_word_t           wr_data;
    logic                ext_wr_en, ext_rd_en, ext_rd_valid, ext_err;
    logic [EXT_AW-1:0]   ext_addr;
    act_word_t           ext_wr_data, ext_rd_data;
    logic                swap_req, swap_ack;
    logic [BANK_LOG-1:0] rd_bank, wr_bank;

    modport master (
        output rd_en, rd_parallel, rd_addr, wr_en, wr_addr, wr_data,
               ext_wr_en, ext_rd_en, ext_addr, ext_wr_data, swap_req,
        input  rd_ready, rd_valid, rd_data, ext_rd_valid, ext_rd_data, ext_err,
               swap_ack, rd_bank, wr_bank
    );
    modport slave (
        input  rd_en, rd_parallel, rd_addr, wr_en, wr_addr, wr_data,
               ext_wr_en, ext_rd_en, ext_addr, ext_wr_data, swap_req,
        output rd_ready, rd_valid, rd_data, ext_rd_valid, ext_rd_data, ext_err,
               swap_ack, rd_bank, wr_bank
    );
endinterface

// File: rtl/act_mem_bank.sv
// act_mem_bank: behavioural 1R1W bank, 1-cycle read latency, read-during-write returns old data
module act_mem_bank
    import act_mem_rotating_banks_pkg::*;
(
    input  logic                 clk,
    input  logic                 re_i,
    input  logic [DEPTH_LOG-1:0] ra_i,
    input  logic                 we_i,
    input  logic [DEPTH_LOG-1:0] wa_i,
    input  act_word_t            wd_i,
    output act_word_t            rd_o
);
    act_word_t mem [BANK_DEPTH];
    act_word_t rd_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[wa_i] <= wd_i;
        if (re_i) rd_q <= mem[ra_i];
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/act_mem_rotating_banks.sv
// act_mem_rotating_banks: N-bank rotating activation buffer; ACT_MEM_ZERO_PAD_EN zero-pads windows past the last word
module act_mem_rotating_banks
    import act_mem_rotating_banks_pkg::*;
(
    input  logic clk,
    input  logic reset,
    act_mem_rotating_banks_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0, FETCH2 = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [BANK_LOG-1:0]  ptr_q, ptr_d, wrb, eb, eb_q;
    logic [DEPTH_LOG-1:0] w, w1_q, ew, rd_ra;
    logic [N_DIM_LOG-1:0] off, off_q;
    logic                 rv_q, two_q, erv_q, eerr_q;
    logic                 idle, acc, unal, pad, rd_re, bad, ewr, erd, swap;
    act_word_t            lo_q, bo, lo, hi, win;
    act_word_t            bank_rd [N_BANKS];

    assign idle  = state_q == IDLE;
    assign off   = bus.rd_addr[N_DIM_LOG-1:0];
    assign w     = bus.rd_addr[N_DIM_LOG +: DEPTH_LOG];
    assign acc   = idle & bus.rd_en;
    assign unal  = acc & ~bus.rd_parallel & (off != '0);
`ifdef ACT_MEM_ZERO_PAD_EN
    assign pad   = unal & (w == '1);
`else
    assign pad   = 1'b0;
`endif
    assign rd_re = acc | ~idle;
    assign rd_ra = idle ? w : w1_q;
    assign wrb   = (ptr_q == BANK_LOG'(N_BANKS-1)) ? '0 : ptr_q + 1'b1;
    assign swap  = bus.swap_req & idle & ~bus.rd_en;
    assign eb    = bus.ext_addr[DEPTH_LOG +: BANK_LOG];
    assign ew    = bus.ext_addr[DEPTH_LOG-1:0];
    assign bad   = int'(eb) >= N_BANKS || eb == ptr_q || eb == wrb;
    assign ewr   = bus.ext_wr_en & ~bad;
    assign erd   = bus.ext_rd_en & ~bus.ext_wr_en & ~bad;

    assign state_d = (unal & ~pad) ? FETCH2 : IDLE;
    assign ptr_d   = swap ? wrb : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rv_q    <= 1'b0;
            two_q   <= 1'b0;
            off_q   <= '0;
            w1_q    <= '0;
            lo_q    <= '0;
            erv_q   <= 1'b0;
            eb_q    <= '0;
            eerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rv_q    <= acc & ~(unal & ~pad) | ~idle;
            two_q   <= ~idle;
            if (acc) off_q <= bus.rd_parallel ? '0 : off;
            if (idle) w1_q <= w + 1'b1;
            lo_q    <= bo;
            erv_q   <= erd;
            eb_q    <= eb;
            eerr_q  <= ((bus.ext_wr_en | bus.ext_rd_en) & bad) | (bus.ext_wr_en & bus.ext_rd_en);
        end
    end

    // second-fetch output: first word was parked in lo_q, bank now holds word w+1
    assign bo  = bank_rd[ptr_q];
    assign lo  = two_q ? lo_q : bo;
    assign hi  = two_q ? bo : '0;
    assign win = act_word_t'({hi, lo} >> (off_q * DATA_W));

    assign bus.rd_ready     = idle;
    assign bus.rd_valid     = rv_q;
    assign bus.rd_data      = rv_q ? win : '0;
    assign bus.ext_rd_valid = erv_q;
    assign bus.ext_rd_data  = erv_q ? bank_rd[eb_q] : '0;
    assign bus.ext_err      = eerr_q;
    assign bus.swap_ack     = swap;
    assign bus.rd_bank      = ptr_q;
    assign bus.wr_bank      = wrb;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic rsel, wsel, ehit;
        assign rsel = ptr_q == BANK_LOG'(b);
        assign wsel = wrb == BANK_LOG'(b);
        assign ehit = eb == BANK_LOG'(b);
        act_mem_bank u_bank (
            .clk  (clk),
            .re_i (rsel ? rd_re : erd & ehit),
            .ra_i (rsel ? rd_ra : ew),
            .we_i (wsel ? bus.wr_en : ewr & ehit),
            .wa_i (wsel ? bus.wr_addr : ew),
            .wd_i (wsel ? bus.wr_data : bus.ext_wr_data),
            .rd_o (bank_rd[b])
        );
    end
endmodule

// File: tb/tb_act_mem_rotating_banks.sv
// tb_act_mem_rotating_banks: directed self-checking bench for the rotating activation buffer
module tb_act_mem_rotating_banks;
    import act_mem_rotating_banks_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    int words [6] = '{0, 1, 2, 4, 255, 7};
`ifdef ACT_MEM_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    always #5 clk = ~clk;

    act_mem_rotating_banks_if bus ();
    act_mem_rotating_banks u_dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chkw(input string tag, input act_word_t obs, input act_word_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // element e of bank b holds e + 37*b (mod 256)
    function automatic act_word_t wpat(input int b, input int a);
        act_word_t r;
        for (int j = 0; j < N_DIM; j++) r[j*DATA_W +: DATA_W] = DATA_W'(a*N_DIM + j + b*37);
        return r;
    endfunction

    function automatic act_word_t win(input int b, input int addr, input bit pz);
        act_word_t r;
        int e;
        for (int j = 0; j < N_DIM; j++) begin
            e = addr + j;
            r[j*DATA_W +: DATA_W] = (pz && e >= N_DIM*BANK_DEPTH) ? '0
                                  : DATA_W'((e % (N_DIM*BANK_DEPTH)) + b*37);
        end
        return r;
    endfunction

    function automatic logic [EXT_AW-1:0] ea(input int b, input int a);
        return {BANK_LOG'(b), DEPTH_LOG'(a)};
    endfunction

    task automatic idle_in;
        bus.rd_en = 0; bus.rd_parallel = 0; bus.rd_addr = '0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.ext_wr_en = 0; bus.ext_rd_en = 0; bus.ext_addr = '0; bus.ext_wr_data = '0;
        bus.swap_req = 0;
    endtask

    task automatic ext_wr(input int b, input int a, input act_word_t d, input int exp_err);
        bus.ext_wr_en = 1; bus.ext_addr = ea(b, a); bus.ext_wr_data = d;
        @(negedge clk);
        bus.ext_wr_en = 0;
        chki("ext_wr_err", int'(bus.ext_err), exp_err);
    endtask

    task automatic ext_rd(input int b, input int a, input act_word_t exp, input string tag);
        bus.ext_rd_en = 1; bus.ext_addr = ea(b, a);
        @(negedge clk);
        bus.ext_rd_en = 0;
        chki({tag, "_valid"}, int'(bus.ext_rd_valid), 1);
        chkw(tag, bus.ext_rd_data, exp);
    endtask

    task automatic aread(input int addr, input act_word_t exp, input string tag);
        bus.rd_en = 1; bus.rd_parallel = 1; bus.rd_addr = ADDR_W'(addr);
        #1 chki({tag, "_ready"}, int'(bus.rd_ready), 1);
        @(negedge clk);
        bus.rd_en = 0;
        chki({tag, "_valid"}, int'(bus.rd_valid), 1);
        chkw(tag, bus.rd_data, exp);
    endtask

    task automatic uread(input int addr, input act_word_t exp, input int lat, input string tag);
        bus.rd_en = 1; bus.rd_parallel = 0; bus.rd_addr = ADDR_W'(addr);
        @(negedge clk);
        if (lat == 2) begin
            chki({tag, "_busy"}, int'(bus.rd_ready), 0);
            chki({tag, "_early"}, int'(bus.rd_valid), 0);
            @(negedge clk);
        end
        bus.rd_en = 0;
        chki({tag, "_valid"}, int'(bus.rd_valid), 1);
        chkw(tag, bus.rd_data, exp);
    endtask

    task automatic swap(input int nb);
        bus.swap_req = 1;
        #1 chki("swap_ack", int'(bus.swap_ack), 1);
        @(negedge clk);
        bus.swap_req = 0;
        chki("swap_rd_bank", int'(bus.rd_bank), nb);
        chki("swap_wr_bank", int'(bus.wr_bank), (nb + 1) % N_BANKS);
    endtask

    initial begin
        idle_in();
        #2 reset = 1;
        @(negedge clk);
        @(negedge clk);
        chki("rst_rd_valid", int'(bus.rd_valid), 0);
        chkw("rst_rd_data", bus.rd_data, '0);
        chki("rst_rd_ready", int'(bus.rd_ready), 1);
        chki("rst_ext_valid", int'(bus.ext_rd_valid), 0);
        chkw("rst_ext_data", bus.ext_rd_data, '0);
        chki("rst_ext_err", int'(bus.ext_err), 0);
        chki("rst_swap_ack", int'(bus.swap_ack), 0);
        chki("rst_rd_bank", int'(bus.rd_bank), 0);
        chki("rst_wr_bank", int'(bus.wr_bank), 1);
        reset = 0;
        @(negedge clk);

        // ptr=0: compute fills bank 1 while the host fills banks 2 and 3
        foreach (words[i]) begin
            bus.wr_en = 1; bus.wr_addr = DEPTH_LOG'(words[i]); bus.wr_data = wpat(1, words[i]);
            ext_wr(2, words[i], wpat(2, words[i]), 0);
            bus.wr_en = 0;
            ext_wr(3, words[i], wpat(3, words[i]), 0);
        end
        ext_rd(2, 4, wpat(2, 4), "ext_rd_b2");

        ext_wr(0, 7, '1, 1);
        @(negedge clk);
        chki("ext_err_pulse", int'(bus.ext_err), 0);
        bus.ext_rd_en = 1; bus.ext_addr = ea(1, 4);
        @(negedge clk);
        bus.ext_rd_en = 0;
        chki("ext_rd_wrbank_valid", int'(bus.ext_rd_valid), 0);
        chki("ext_rd_wrbank_err", int'(bus.ext_err), 1);
        bus.ext_wr_en = 1; bus.ext_rd_en = 1; bus.ext_addr = ea(2, 9); bus.ext_wr_data = wpat(2, 9);
        @(negedge clk);
        bus.ext_wr_en = 0; bus.ext_rd_en = 0;
        chki("rdwr_err", int'(bus.ext_err), 1);
        chki("rdwr_no_valid", int'(bus.ext_rd_valid), 0);
        ext_rd(2, 9, wpat(2, 9), "rdwr_landed");

        swap(1);
        foreach (words[i]) ext_wr(0, words[i], wpat(0, words[i]), 0);
        aread('h40, wpat(1, 4), "aread_b1");

        bus.rd_en = 1; bus.rd_parallel = 1; bus.rd_addr = ADDR_W'('h40);
        @(negedge clk);
        chki("b2b_valid0", int'(bus.rd_valid), 1);
        chkw("b2b_data0", bus.rd_data, wpat(1, 4));
        bus.rd_addr = ADDR_W'('h10);
        #1 chki("b2b_ready1", int'(bus.rd_ready), 1);
        @(negedge clk);
        bus.rd_en = 0;
        chki("b2b_valid1", int'(bus.rd_valid), 1);
        chkw("b2b_data1", bus.rd_data, wpat(1, 1));

        // swap requested during an unaligned read waits for IDLE with rd_en low
        bus.swap_req = 1; bus.rd_en = 1; bus.rd_parallel = 0; bus.rd_addr = ADDR_W'('h13);
        #1 chki("swap_blk_req", int'(bus.swap_ack), 0);
        @(negedge clk);
        chki("u13_busy", int'(bus.rd_ready), 0);
        chki("u13_early", int'(bus.rd_valid), 0);
        #1 chki("swap_blk_fetch2", int'(bus.swap_ack), 0);
        @(negedge clk);
        bus.rd_en = 0;
        chki("u13_valid", int'(bus.rd_valid), 1);
        chkw("u13_data", bus.rd_data, win(1, 'h13, 1'b0));
        #1 chki("swap_after_rd", int'(bus.swap_ack), 1);
        @(negedge clk);
        bus.swap_req = 0;
        chki("swap_rd_bank2", int'(bus.rd_bank), 2);

        aread('h40, wpat(2, 4), "aread_b2");
        aread('h13, wpat(2, 1), "par_unaligned");
        uread('h20, wpat(2, 2), 1, "u_off0");
        uread('hFF5, win(2, 'hFF5, PAD), PAD ? 1 : 2, "u_last");
        uread('h13, win(2, 'h13, 1'b0), 2, "u13_b2");

        swap(3);
        ext_wr(0, 7, '1, 1);
        swap(0);
        swap(1);
        ext_rd(0, 7, wpat(0, 7), "b0_unchanged");

        bus.rd_en = 1; bus.rd_parallel = 0; bus.rd_addr = ADDR_W'('h13);
        @(negedge clk);
        bus.rd_en = 0;
        reset = 1;
        #1 chki("rstf_ready_async", int'(bus.rd_ready), 1);
        @(negedge clk);
        chki("rstf_valid", int'(bus.rd_valid), 0);
        chkw("rstf_data", bus.rd_data, '0);
        chki("rstf_rd_bank", int'(bus.rd_bank), 0);
        chki("rstf_wr_bank", int'(bus.wr_bank), 1);
        chki("rstf_ext_err", int'(bus.ext_err), 0);
        chki("rstf_ext_valid", int'(bus.ext_rd_valid), 0);
        reset = 0;
        @(negedge clk);
        chki("rstf_no_late_valid", int'(bus.rd_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
